// File: rtl/pe_job_scheduler.sv
// pe_job_scheduler: queues {base, len} jobs and streams each one as a
// read -> PE -> write pipeline over a 2^AW-word buffer, one word per cycle.
// Jobs run back to back with no bubble when the next job is already queued.
module pe_job_scheduler #(
    parameter int AW     = 4,
    parameter int QDEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [AW-1:0]           job_base,
    input  logic [AW-1:0]           job_len,
    output logic                    en_rd,
    output logic [AW-1:0]           addr_rd,
    output logic                    en_pe,
    output logic                    en_wr,
    output logic [AW-1:0]           addr_wr,
    output logic                    job_done,
    output logic                    busy,
    output logic [$clog2(QDEPTH):0] q_count
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    // Job queue storage and bookkeeping
    logic [AW-1:0] r_q_base [QDEPTH];
    logic [AW-1:0] r_q_len  [QDEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Control
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_q_empty;
    logic          w_rd_last;
    logic          w_pipe_empty;
    logic [AW-1:0] w_head_base;
    logic [AW-1:0] w_head_len;

    // Read stage: current address and words left after this one
    logic          r_en_rd;
    logic [AW-1:0] r_addr_rd;
    logic [AW-1:0] r_rd_cnt;

    // PE stage and write stage, each carrying its address and last-word tag
    logic          r_en_pe;
    logic [AW-1:0] r_pe_addr;
    logic          r_pe_last;
    logic          r_en_wr;
    logic [AW-1:0] r_addr_wr;
    logic          r_wr_last;

    // Circular-pointer advance that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // job_ready depends only on the registered count, never on job_valid, so
    // a full queue refuses a push even in the cycle it pops.
    assign job_ready    = (r_count < CW'(QDEPTH));
    assign w_push       = job_valid & job_ready & ~clr;
    assign w_q_empty    = (r_count == '0);
    assign w_head_base  = r_q_base[r_rptr];
    assign w_head_len   = r_q_len[r_rptr];
    assign w_rd_last    = r_en_rd & (r_rd_cnt == '0);
    assign w_pipe_empty = ~r_en_pe & ~r_en_wr;

    // Queue payload write on an accepted push.
    // NOTE: the payload array has no reset; a word is only ever read after it
    // has been written, and the pointers/count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_base[r_wptr] <= job_base;
            r_q_len[r_wptr]  <= job_len;
        end
    end

    // Queue pointers and occupancy; clr empties the queue at the next edge.
    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and head-of-queue pop decision.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_q_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_rd_last) begin
                    if (!w_q_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pipe_empty) begin
                    if (!w_q_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (clr) begin
            w_pop       = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    // Read stage: load a popped job, otherwise step the address until the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_rd   <= 1'b0;
            r_addr_rd <= '0;
            r_rd_cnt  <= '0;
        end else if (clr) begin
            r_en_rd <= 1'b0;
        end else if (w_pop) begin
            r_en_rd   <= 1'b1;
            r_addr_rd <= w_head_base;
            r_rd_cnt  <= w_head_len;
        end else if (r_en_rd) begin
            if (r_rd_cnt == '0) begin
                r_en_rd <= 1'b0;
            end else begin
                r_addr_rd <= r_addr_rd + AW'(1);
                r_rd_cnt  <= r_rd_cnt - AW'(1);
            end
        end
    end

    // PE and write stages: shift valid/last tags, hold addresses when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_pe   <= 1'b0;
            r_pe_addr <= '0;
            r_pe_last <= 1'b0;
            r_en_wr   <= 1'b0;
            r_addr_wr <= '0;
            r_wr_last <= 1'b0;
        end else if (clr) begin
            r_en_pe   <= 1'b0;
            r_pe_last <= 1'b0;
            r_en_wr   <= 1'b0;
            r_wr_last <= 1'b0;
        end else begin
            r_en_pe   <= r_en_rd;
            r_pe_last <= w_rd_last;
            if (r_en_rd) r_pe_addr <= r_addr_rd;
            r_en_wr   <= r_en_pe;
            r_wr_last <= r_pe_last;
            if (r_en_pe) r_addr_wr <= r_pe_addr;
        end
    end

    assign en_rd    = r_en_rd;
    assign addr_rd  = r_addr_rd;
    assign en_pe    = r_en_pe;
    assign en_wr    = r_en_wr;
    assign addr_wr  = r_addr_wr;
    assign job_done = r_en_wr & r_wr_last;
    assign busy     = (r_state != S_IDLE) | (r_count != '0) | r_en_rd | r_en_pe | r_en_wr;
    assign q_count  = r_count;

endmodule

// File: tb/tb_pe_job_scheduler.sv
// Scoreboard bench for pe_job_scheduler: accepted jobs expand into an expected
// word stream; a negedge monitor consumes it as reads and writes appear.
module tb_pe_job_scheduler;

    localparam int AW = 4;
    localparam int QD = 4;
    localparam int NE = 8192;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          clr       = 1'b0;
    logic          job_valid = 1'b0;
    logic [AW-1:0] job_base  = '0;
    logic [AW-1:0] job_len   = '0;
    logic          job_ready;
    logic          en_rd;
    logic [AW-1:0] addr_rd;
    logic          en_pe;
    logic          en_wr;
    logic [AW-1:0] addr_wr;
    logic          job_done;
    logic          busy;
    logic [2:0]    q_count;

    pe_job_scheduler #(.AW(AW), .QDEPTH(QD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_base  (job_base),
        .job_len   (job_len),
        .en_rd     (en_rd),
        .addr_rd   (addr_rd),
        .en_pe     (en_pe),
        .en_wr     (en_wr),
        .addr_wr   (addr_wr),
        .job_done  (job_done),
        .busy      (busy),
        .q_count   (q_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected word stream (written only by the model process)
    logic [AW-1:0] e_addr [NE];
    bit            e_last [NE];
    int            tail      = 0;
    int            flush_cnt = 0;
    int            flush_to  = 0;

    // Reference model: an accepted job becomes len+1 words base, base+1, ...
    // mod 16, the final one tagged last. clr or reset discards everything.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || clr) begin
                flush_to = tail;
                flush_cnt++;
            end else if (job_valid && job_ready) begin
                for (int i = 0; i <= int'(job_len); i++) begin
                    if (tail < NE) begin
                        e_addr[tail] = job_base + AW'(i);
                        e_last[tail] = (i == int'(job_len));
                        tail++;
                    end
                end
            end
        end
    end

    // Monitor state (written only by the monitor process)
    int            rd_head    = 0;
    int            wr_head    = 0;
    int            seen_flush = 0;
    int            n_rd       = 0;
    int            n_wr       = 0;
    int            n_done     = 0;
    bit            p1_en      = 0;
    bit            p2_en      = 0;
    logic [AW-1:0] p1_addr    = '0;
    logic [AW-1:0] p2_addr    = '0;

    // Monitor: pop expected words on each read and write, check pipeline lags.
    initial begin
        forever begin
            @(negedge clk);
            if (flush_cnt != seen_flush) begin
                seen_flush = flush_cnt;
                rd_head    = flush_to;
                wr_head    = flush_to;
                p1_en      = 0;
                p2_en      = 0;
            end
            if (rst_n) begin
                check("en_pe_lag", int'(en_pe), int'(p1_en));
                check("en_wr_lag", int'(en_wr), int'(p2_en));
                if (rd_head != tail || wr_head != tail) check("busy_with_work", int'(busy), 1);
                if (en_rd) begin
                    check("rd_expected", int'(rd_head < tail), 1);
                    if (rd_head < tail) begin
                        check("addr_rd", int'(addr_rd), int'(e_addr[rd_head]));
                        rd_head++;
                    end
                    n_rd++;
                end
                if (en_wr) begin
                    check("addr_wr_lag", int'(addr_wr), int'(p2_addr));
                    check("wr_expected", int'(wr_head < tail), 1);
                    if (wr_head < tail) begin
                        check("addr_wr", int'(addr_wr), int'(e_addr[wr_head]));
                        check("job_done_last", int'(job_done), int'(e_last[wr_head]));
                        wr_head++;
                    end
                    n_wr++;
                    if (job_done) n_done++;
                end else begin
                    check("done_without_wr", int'(job_done), 0);
                end
            end
            p2_en   = p1_en;
            p2_addr = p1_addr;
            p1_en   = rst_n && en_rd;
            p1_addr = addr_rd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [AW-1:0] b, input logic [AW-1:0] l);
        bit rdy;
        rdy       = 0;
        job_valid = 1'b1;
        job_base  = b;
        job_len   = l;
        for (int i = 0; i < 60 && !rdy; i++) begin
            rdy = job_ready;
            step();
        end
        job_valid = 1'b0;
        check("push_accepted", int'(rdy), 1);
    endtask

    task automatic wait_en_rd(input int budget);
        for (int i = 0; i < budget && !en_rd; i++) step();
        check("saw_en_rd", int'(en_rd), 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) step();
        check("busy_falls", int'(busy), 0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_en_rd"},     int'(en_rd), 0);
        check({tag, "_en_pe"},     int'(en_pe), 0);
        check({tag, "_en_wr"},     int'(en_wr), 0);
        check({tag, "_addr_rd"},   int'(addr_rd), 0);
        check({tag, "_addr_wr"},   int'(addr_wr), 0);
        check({tag, "_job_done"},  int'(job_done), 0);
        check({tag, "_busy"},      int'(busy), 0);
        check({tag, "_q_count"},   int'(q_count), 0);
        check({tag, "_job_ready"}, int'(job_ready), 1);
    endtask

    int r0, w0, d0, issued;
    int wrap_seq [4] = '{14, 15, 0, 1};
    int b2b_seq  [3] = '{2, 3, 8};

    initial begin
        #2;
        check_reset_outs("rst");
        #10 rst_n = 1'b1;
        step();

        // Single 16-word job
        r0 = n_rd; w0 = n_wr; d0 = n_done;
        push_job(4'd0, 4'd15);
        wait_idle(100);
        check("single_reads", n_rd - r0, 16);
        check("single_writes", n_wr - w0, 16);
        check("single_done", n_done - d0, 1);

        // Address wrap 14,15,0,1
        w0 = n_wr; d0 = n_done;
        push_job(4'd14, 4'd3);
        wait_en_rd(10);
        for (int k = 0; k < 4; k++) begin
            check("wrap_en_rd", int'(en_rd), 1);
            check("wrap_addr_rd", int'(addr_rd), wrap_seq[k]);
            step();
        end
        check("wrap_rd_stops", int'(en_rd), 0);
        wait_idle(50);
        check("wrap_writes", n_wr - w0, 4);
        check("wrap_done", n_done - d0, 1);

        // Back-to-back jobs with no read gap
        d0 = n_done;
        push_job(4'd2, 4'd1);
        push_job(4'd8, 4'd0);
        wait_en_rd(10);
        for (int k = 0; k < 3; k++) begin
            check("b2b_en_rd", int'(en_rd), 1);
            check("b2b_addr_rd", int'(addr_rd), b2b_seq[k]);
            step();
        end
        check("b2b_rd_stops", int'(en_rd), 0);
        wait_idle(50);
        check("b2b_done", n_done - d0, 2);

        // Full queue: four accepted, fifth held until the first pop
        d0 = n_done;
        push_job(4'd0, 4'd15);
        wait_en_rd(10);
        for (int k = 1; k <= 4; k++) push_job(AW'(k), 4'd0);
        check("full_q_count", int'(q_count), 4);
        check("full_ready", int'(job_ready), 0);
        job_base  = 4'd9;
        job_len   = 4'd0;
        job_valid = 1'b1;
        repeat (5) step();
        check("held_q_count", int'(q_count), 4);
        check("held_ready", int'(job_ready), 0);
        for (int i = 0; i < 40 && !job_ready; i++) step();
        check("ready_after_pop", int'(job_ready), 1);
        check("q_before_pushpop", int'(q_count), 3);
        step();
        job_valid = 1'b0;
        check("q_after_pushpop", int'(q_count), 3);
        wait_idle(100);
        check("full_done", n_done - d0, 6);

        // clr mid-job: 5 reads issued, 2 jobs queued, offer dropped
        r0 = n_rd; d0 = n_done;
        push_job(4'd0, 4'd15);
        push_job(4'd4, 4'd3);
        push_job(4'd8, 4'd3);
        issued = 0;
        for (int i = 0; i < 40; i++) begin
            issued = (n_rd - r0) + int'(en_rd);
            if (issued >= 5) break;
            step();
        end
        check("clr_reads_before", issued, 5);
        check("clr_q_before", int'(q_count), 2);
        clr       = 1'b1;
        job_valid = 1'b1;
        job_base  = 4'd12;
        job_len   = 4'd0;
        step();
        clr       = 1'b0;
        job_valid = 1'b0;
        check("clr_en_rd", int'(en_rd), 0);
        check("clr_en_pe", int'(en_pe), 0);
        check("clr_en_wr", int'(en_wr), 0);
        check("clr_q_count", int'(q_count), 0);
        check("clr_busy", int'(busy), 0);
        repeat (20) step();
        check("clr_no_done", n_done - d0, 0);
        check("clr_reads_total", n_rd - r0, 5);

        // Asynchronous reset in the middle of a RUN cycle
        d0 = n_done;
        push_job(4'd0, 4'd15);
        wait_en_rd(10);
        repeat (3) step();
        #3 rst_n = 1'b0;
        #1 check_reset_outs("arst");
        step();
        #2 rst_n = 1'b1;
        r0 = n_rd;
        repeat (20) step();
        check("arst_no_done", n_done - d0, 0);
        check("arst_no_reads", n_rd - r0, 0);
        d0 = n_done;
        push_job(4'd3, 4'd1);
        wait_idle(50);
        check("arst_resume_done", n_done - d0, 1);

        // Randomized traffic with occasional clr
        for (int c = 0; c < 400; c++) begin
            job_valid = ($urandom_range(0, 2) != 0);
            job_base  = AW'($urandom_range(0, 15));
            job_len   = ($urandom_range(0, 7) == 0) ? 4'd15 : AW'($urandom_range(0, 3));
            clr       = ($urandom_range(0, 59) == 0);
            step();
        end
        job_valid = 1'b0;
        clr       = 1'b0;
        wait_idle(400);
        step();
        check("final_drained", int'(wr_head == tail), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
